// File: rtl/id_rename_stage_pkg.sv
// Shared types for the decode/rename stage: packets, CDB tag, decode bundle and ALU/FU enums.
// Also holds the funct3 -> ALU op helpers used by the instruction decoder.
package id_rename_stage_pkg;
  localparam int N                  = 4;
  localparam int RAT_SIZE           = 32;
  localparam int PRF_NUM_ENTRIES    = 64;
  localparam int PRF_NUM_INDEX_BITS = 6;

  localparam logic [31:0] INST_WFI = 32'h1050_0073;

  typedef logic [PRF_NUM_INDEX_BITS-1:0] tag_t;

  typedef enum logic [4:0] {
    ALU_ADD, ALU_SUB, ALU_SLT, ALU_SLTU, ALU_AND, ALU_OR, ALU_XOR, ALU_SLL, ALU_SRL,
    ALU_SRA, ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU, ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU
  } alu_func_e;

  typedef enum logic [2:0] {
    FU_ALU, FU_MULT, FU_DIV, FU_LOAD, FU_STORE, FU_BRANCH, FU_SYS
  } func_unit_e;

  typedef enum logic [1:0] {OPA_REG, OPA_PC, OPA_ZERO} opa_sel_e;
  typedef enum logic [1:0] {OPB_REG, OPB_IMM, OPB_ZERO} opb_sel_e;

  typedef struct packed {
    logic valid;
    tag_t phys_reg;
  } cdb_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] inst;
    logic [31:0] pc;
    logic [31:0] npc;
  } if_id_packet_t;

  typedef struct packed {
    logic       has_dest;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
    opa_sel_e   opa_sel;
    opb_sel_e   opb_sel;
    logic [31:0] imm;
    alu_func_e  alu_func;
    func_unit_e func_unit;
    logic       cond_branch;
    logic       uncond_branch;
    logic       halt;
    logic       csr_op;
    logic       illegal;
  } decode_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] npc;
    logic [31:0] opa_value;
    logic [31:0] opb_value;
    logic [31:0] offset_value;
    logic        opa_ready;
    logic        opb_ready;
    logic [4:0]  dest_reg_idx;
    tag_t        phys_reg_dest;
    alu_func_e   alu_func;
    func_unit_e  func_unit;
    logic        cond_branch;
    logic        uncond_branch;
    logic        halt;
    logic        csr_op;
    logic        illegal;
  } id_ex_packet_t;

  // alt selects SUB/SRA (funct7[5]) for the shared OP / OP-IMM encodings
  function automatic alu_func_e base_alu(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  return alt ? ALU_SUB : ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return alt ? ALU_SRA : ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

  function automatic alu_func_e m_alu(input logic [2:0] f3);
    case (f3)
      3'b000:  return ALU_MUL;
      3'b001:  return ALU_MULH;
      3'b010:  return ALU_MULHSU;
      3'b011:  return ALU_MULHU;
      3'b100:  return ALU_DIV;
      3'b101:  return ALU_DIVU;
      3'b110:  return ALU_REM;
      default: return ALU_REMU;
    endcase
  endfunction
endpackage

// File: rtl/id_rename_stage_if.sv
// Fetch-side packets and CDB tags into the rename stage, renamed packets out to dispatch.
interface id_rename_stage_if;
  import id_rename_stage_pkg::*;
  if_id_packet_t [N-1:0] if_id_packet_in;
  cdb_t          [N-1:0] cdb_in;
  id_ex_packet_t [N-1:0] id_packet_out;

  modport master (output if_id_packet_in, cdb_in, input id_packet_out);
  modport slave  (input if_id_packet_in, cdb_in, output id_packet_out);
endinterface

// File: rtl/id_rename_stage_inst_decoder.sv
// Pure combinational RV32IM decode: register fields, operand selects, immediate, control flags.
module id_rename_stage_inst_decoder
  import id_rename_stage_pkg::*;
(
  input  logic [31:0] inst,
  output decode_t     dec
);
  logic [6:0]  opcode, funct7;
  logic [2:0]  funct3;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

  assign opcode = inst[6:0];
  assign funct3 = inst[14:12];
  assign funct7 = inst[31:25];
  assign imm_i  = {{20{inst[31]}}, inst[31:20]};
  assign imm_s  = {{20{inst[31]}}, inst[31:25], inst[11:7]};
  assign imm_b  = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
  assign imm_u  = {inst[31:12], 12'b0};
  assign imm_j  = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};

  always_comb begin
    dec           = '0;
    dec.rs1       = inst[19:15];
    dec.rs2       = inst[24:20];
    dec.rd        = inst[11:7];
    dec.opa_sel   = OPA_ZERO;
    dec.opb_sel   = OPB_ZERO;
    dec.alu_func  = ALU_ADD;
    dec.func_unit = FU_ALU;
    case (opcode)
      7'b0110111: begin // LUI
        dec.has_dest = 1'b1; dec.opb_sel = OPB_IMM; dec.imm = imm_u;
      end
      7'b0010111: begin // AUIPC
        dec.has_dest = 1'b1; dec.opa_sel = OPA_PC; dec.opb_sel = OPB_IMM; dec.imm = imm_u;
      end
      7'b1101111: begin // JAL
        dec.has_dest = 1'b1; dec.opa_sel = OPA_PC; dec.imm = imm_j;
        dec.uncond_branch = 1'b1; dec.func_unit = FU_BRANCH;
      end
      7'b1100111: begin // JALR
        dec.has_dest = 1'b1; dec.opa_sel = OPA_REG; dec.imm = imm_i;
        dec.uncond_branch = 1'b1; dec.func_unit = FU_BRANCH;
        dec.illegal = (funct3 != 3'b000);
      end
      7'b1100011: begin
        dec.opa_sel = OPA_REG; dec.opb_sel = OPB_REG; dec.imm = imm_b;
        dec.cond_branch = 1'b1; dec.func_unit = FU_BRANCH;
        case (funct3)
          3'b000, 3'b001: dec.alu_func = ALU_SUB;
          3'b100, 3'b101: dec.alu_func = ALU_SLT;
          3'b110, 3'b111: dec.alu_func = ALU_SLTU;
          default:        dec.illegal  = 1'b1;
        endcase
      end
      7'b0000011: begin
        dec.has_dest = 1'b1; dec.opa_sel = OPA_REG; dec.imm = imm_i; dec.func_unit = FU_LOAD;
        dec.illegal = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
      end
      7'b0100011: begin
        dec.opa_sel = OPA_REG; dec.opb_sel = OPB_REG; dec.imm = imm_s; dec.func_unit = FU_STORE;
        dec.illegal = (funct3 > 3'b010);
      end
      7'b0010011: begin
        dec.has_dest = 1'b1; dec.opa_sel = OPA_REG; dec.opb_sel = OPB_IMM; dec.imm = imm_i;
        dec.alu_func = base_alu(funct3, (funct3 == 3'b101) && funct7[5]);
        dec.illegal  = ((funct3 == 3'b001) && (funct7 != 7'h00)) ||
                       ((funct3 == 3'b101) && (funct7 != 7'h00) && (funct7 != 7'h20));
      end
      7'b0110011: begin
        dec.has_dest = 1'b1; dec.opa_sel = OPA_REG; dec.opb_sel = OPB_REG;
        if (funct7 == 7'h01) begin
          dec.alu_func  = m_alu(funct3);
          dec.func_unit = funct3[2] ? FU_DIV : FU_MULT;
        end else if (funct7 == 7'h00) begin
          dec.alu_func = base_alu(funct3, 1'b0);
        end else if ((funct7 == 7'h20) && ((funct3 == 3'b000) || (funct3 == 3'b101))) begin
          dec.alu_func = base_alu(funct3, 1'b1);
        end else begin
          dec.illegal = 1'b1;
        end
      end
      7'b0001111: ; // FENCE: no operands, no destination
      7'b1110011: begin
        dec.func_unit = FU_SYS;
        if (inst == INST_WFI) begin
          dec.halt = 1'b1;
        end else if ((funct3 != 3'b000) && (funct3 != 3'b100)) begin
          // CSR address rides in imm; the immediate forms take no register source
          dec.csr_op = 1'b1; dec.has_dest = 1'b1; dec.imm = imm_i;
          dec.opa_sel = funct3[2] ? OPA_ZERO : OPA_REG;
        end else begin
          dec.illegal = 1'b1;
        end
      end
      default: dec.illegal = 1'b1;
    endcase
  end
endmodule

// File: rtl/id_rename_stage.sv
// N-wide decode + rename: speculative RAT, physical free list and ready bits, RRAT recovery on nuke.
// Outputs are combinational from inputs and state; every valid slot is consumed each cycle.
module id_rename_stage
  import id_rename_stage_pkg::*;
(
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       nuke,
  input  tag_t [RAT_SIZE-1:0]        rrat_entries,
  input  logic [PRF_NUM_ENTRIES-1:0] rrat_free_list,
  input  logic [PRF_NUM_ENTRIES-1:0] free_vector_from_rrat,
  id_rename_stage_if.slave           bus
);
  localparam int KW = $clog2(N);

  tag_t [RAT_SIZE-1:0]        rat, rat_next;
  logic [PRF_NUM_ENTRIES-1:0] free, ready, alloc_mask, cdb_mask, avail;
  decode_t [N-1:0]            dec;
  tag_t [N-1:0]               free_tag;
  logic [N-1:0]               free_found;
  id_ex_packet_t [N-1:0]      pkt;
  logic [RAT_SIZE-1:0]        in_group;
  logic                       blocked, want, ra, rb;
  tag_t                       ta, tb;
  logic [KW-1:0]              k;

  for (genvar i = 0; i < N; i++) begin : g_dec
    id_rename_stage_inst_decoder u_dec (.inst(bus.if_id_packet_in[i].inst), .dec(dec[i]));
  end

  // k-th free tag = k-th lowest set bit of the free vector
  always_comb begin
    avail      = free;
    free_tag   = '0;
    free_found = '0;
    for (int s = 0; s < N; s++) begin
      for (int p = PRF_NUM_ENTRIES - 1; p >= 0; p--)
        if (avail[p]) begin
          free_tag[s]   = tag_t'(p);
          free_found[s] = 1'b1;
        end
      if (free_found[s]) avail[free_tag[s]] = 1'b0;
    end
  end

  always_comb begin
    cdb_mask = '0;
    for (int c = 0; c < N; c++)
      if (bus.cdb_in[c].valid) cdb_mask[bus.cdb_in[c].phys_reg] = 1'b1;
  end

  // Rename chain: each slot sees the RAT as rewritten by older slots in the group.
  // in_group marks arch regs whose current mapping was allocated this cycle (never ready).
  always_comb begin
    rat_next   = rat;
    in_group   = '0;
    alloc_mask = '0;
    pkt        = '0;
    blocked    = !reset || nuke;
    k          = '0;
    want       = 1'b0;
    ta = '0; tb = '0; ra = 1'b0; rb = 1'b0;
    for (int i = 0; i < N; i++) begin
      ta = (dec[i].rs1 == 5'd0) ? tag_t'(0) : rat_next[dec[i].rs1];
      tb = (dec[i].rs2 == 5'd0) ? tag_t'(0) : rat_next[dec[i].rs2];
      ra = (dec[i].rs1 == 5'd0) || (!in_group[dec[i].rs1] && (ready[ta] || cdb_mask[ta]));
      rb = (dec[i].rs2 == 5'd0) || (!in_group[dec[i].rs2] && (ready[tb] || cdb_mask[tb]));
      want = bus.if_id_packet_in[i].valid && !dec[i].illegal && dec[i].has_dest &&
             (dec[i].rd != 5'd0);
      if (want && !free_found[k]) blocked = 1'b1;

      pkt[i].valid         = bus.if_id_packet_in[i].valid && !dec[i].illegal && !blocked;
      pkt[i].pc            = bus.if_id_packet_in[i].pc;
      pkt[i].npc           = bus.if_id_packet_in[i].npc;
      pkt[i].dest_reg_idx  = dec[i].rd;
      pkt[i].alu_func      = dec[i].alu_func;
      pkt[i].func_unit     = dec[i].func_unit;
      pkt[i].cond_branch   = dec[i].cond_branch;
      pkt[i].uncond_branch = dec[i].uncond_branch;
      pkt[i].halt          = dec[i].halt;
      pkt[i].csr_op        = dec[i].csr_op;
      pkt[i].illegal       = dec[i].illegal;
      pkt[i].offset_value  = (dec[i].opb_sel == OPB_IMM) ? 32'd0 : dec[i].imm;
      case (dec[i].opa_sel)
        OPA_REG: pkt[i].opa_value = 32'(ta);
        OPA_PC:  pkt[i].opa_value = bus.if_id_packet_in[i].pc;
        default: pkt[i].opa_value = 32'd0;
      endcase
      case (dec[i].opb_sel)
        OPB_REG: pkt[i].opb_value = 32'(tb);
        OPB_IMM: pkt[i].opb_value = dec[i].imm;
        default: pkt[i].opb_value = 32'd0;
      endcase
      pkt[i].opa_ready = (dec[i].opa_sel != OPA_REG) || ra;
      pkt[i].opb_ready = (dec[i].opb_sel != OPB_REG) || rb;

      if (pkt[i].valid && want) begin
        pkt[i].phys_reg_dest        = free_tag[k];
        alloc_mask[free_tag[k]]     = 1'b1;
        rat_next[dec[i].rd]         = free_tag[k];
        in_group[dec[i].rd]         = 1'b1;
        k                           = k + 1'b1;
      end
    end
  end

  assign bus.id_packet_out = pkt;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int r = 0; r < RAT_SIZE; r++) rat[r] <= tag_t'(r);
      free  <= {{(PRF_NUM_ENTRIES-RAT_SIZE){1'b1}}, {RAT_SIZE{1'b0}}};
      ready <= '1;
    end else if (nuke) begin
      rat   <= rrat_entries;
      free  <= rrat_free_list;
      ready <= '1;
    end else begin
      rat   <= rat_next;
      free  <= (free | free_vector_from_rrat) & ~alloc_mask;
      ready <= (ready | cdb_mask) & ~alloc_mask;
    end
  end
endmodule

// File: tb/tb_id_rename_stage.sv
// Directed bench for id_rename_stage: expectations queued at drive time, popped and asserted mid-cycle.
module tb_id_rename_stage;
  import id_rename_stage_pkg::*;

  logic clock = 1'b0;
  logic reset, nuke;
  tag_t [RAT_SIZE-1:0]        rrat_entries;
  logic [PRF_NUM_ENTRIES-1:0] rrat_free_list, free_vector_from_rrat;

  id_rename_stage_if bus();

  id_rename_stage dut (
    .clock                 (clock),
    .reset                 (reset),
    .nuke                  (nuke),
    .rrat_entries          (rrat_entries),
    .rrat_free_list        (rrat_free_list),
    .free_vector_from_rrat (free_vector_from_rrat),
    .bus                   (bus)
  );

  always #5 clock = ~clock;

  typedef enum int {F_VALID, F_ILLEGAL, F_DEST, F_OPA, F_OPA_RDY, F_OPB, F_OPB_RDY, F_HALT} field_e;
  typedef struct {
    string       tag;
    int          slot;
    field_e      field;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  function automatic logic [31:0] addi(int rd, int rs1, int imm);
    return {imm[11:0], 5'(rs1), 3'b000, 5'(rd), 7'b0010011};
  endfunction

  function automatic logic [31:0] add(int rd, int rs1, int rs2);
    return {7'b0, 5'(rs2), 5'(rs1), 3'b000, 5'(rd), 7'b0110011};
  endfunction

  task automatic clear_inputs();
    bus.if_id_packet_in = '0;
    bus.cdb_in          = '0;
  endtask

  task automatic drive(int s, logic [31:0] inst);
    bus.if_id_packet_in[s].valid = 1'b1;
    bus.if_id_packet_in[s].inst  = inst;
    bus.if_id_packet_in[s].pc    = 32'h1000 + 32'(4 * s);
    bus.if_id_packet_in[s].npc   = 32'h1004 + 32'(4 * s);
  endtask

  task automatic expect_f(string tag, int s, field_e f, logic [31:0] v);
    sb.push_back('{tag: tag, slot: s, field: f, val: v});
  endtask

  function automatic logic [31:0] observe(int s, field_e f);
    case (f)
      F_VALID:   return 32'(bus.id_packet_out[s].valid);
      F_ILLEGAL: return 32'(bus.id_packet_out[s].illegal);
      F_DEST:    return 32'(bus.id_packet_out[s].phys_reg_dest);
      F_OPA:     return bus.id_packet_out[s].opa_value;
      F_OPA_RDY: return 32'(bus.id_packet_out[s].opa_ready);
      F_OPB:     return bus.id_packet_out[s].opb_value;
      F_OPB_RDY: return 32'(bus.id_packet_out[s].opb_ready);
      default:   return 32'(bus.id_packet_out[s].halt);
    endcase
  endfunction

  // Inputs are driven 1 time unit after a rising edge; compare mid-cycle, then advance one clock.
  task automatic run_step();
    exp_t        e;
    logic [31:0] obs;
    #4;
    while (sb.size() > 0) begin
      e   = sb.pop_front();
      obs = observe(e.slot, e.field);
      checks++;
      assert (obs === e.val) else begin
        errors++;
        $error("FAIL %s slot%0d: observed %0h expected %0h", e.tag, e.slot, obs, e.val);
      end
    end
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset = 1'b0;
    nuke  = 1'b0;
    for (int r = 0; r < RAT_SIZE; r++) rrat_entries[r] = tag_t'(r);
    rrat_free_list        = {32'hFFFF_FFFF, 32'h0};
    free_vector_from_rrat = '0;
    clear_inputs();
    @(posedge clock);
    #1;

    // while held in reset nothing is valid
    for (int s = 0; s < N; s++) begin
      drive(s, addi(s + 1, 0, 1));
      expect_f("reset_valid", s, F_VALID, 0);
    end
    run_step();
    reset = 1'b1;

    // inst==0 is illegal and must not consume tags
    clear_inputs();
    for (int s = 0; s < N; s++) begin
      drive(s, 32'h0);
      expect_f("zero_valid", s, F_VALID, 0);
      expect_f("zero_illegal", s, F_ILLEGAL, 1);
    end
    run_step();

    clear_inputs();
    for (int s = 0; s < N; s++) begin
      drive(s, addi(s + 1, 0, 1));
      expect_f("addi_valid", s, F_VALID, 1);
      expect_f("addi_dest", s, F_DEST, 32 + s);
      expect_f("addi_opa", s, F_OPA, 0);
      expect_f("addi_opa_rdy", s, F_OPA_RDY, 1);
      expect_f("addi_opb_imm", s, F_OPB, 1);
    end
    run_step();

    // intra-group dependency; CDB tag 36 must not bypass a same-group producer
    clear_inputs();
    drive(0, add(5, 1, 1));
    drive(1, add(6, 5, 5));
    drive(2, INST_WFI);
    bus.cdb_in[0] = '{valid: 1'b1, phys_reg: tag_t'(36)};
    expect_f("dep_s0_dest", 0, F_DEST, 36);
    expect_f("dep_s0_opa", 0, F_OPA, 32);
    expect_f("dep_s0_opa_rdy", 0, F_OPA_RDY, 0);
    expect_f("dep_s0_opb_rdy", 0, F_OPB_RDY, 0);
    expect_f("dep_s1_dest", 1, F_DEST, 37);
    expect_f("dep_s1_opa", 1, F_OPA, 36);
    expect_f("dep_s1_opb", 1, F_OPB, 36);
    expect_f("dep_s1_opa_rdy", 1, F_OPA_RDY, 0);
    expect_f("dep_s1_opb_rdy", 1, F_OPB_RDY, 0);
    expect_f("wfi_valid", 2, F_VALID, 1);
    expect_f("wfi_halt", 2, F_HALT, 1);
    expect_f("wfi_dest", 2, F_DEST, 0);
    expect_f("empty_slot", 3, F_VALID, 0);
    run_step();

    // same-cycle CDB bypass on tag 32; allocation beat CDB on tag 36 last edge
    clear_inputs();
    drive(0, add(7, 1, 0));
    drive(1, add(8, 5, 0));
    bus.cdb_in[2] = '{valid: 1'b1, phys_reg: tag_t'(32)};
    expect_f("byp_opa", 0, F_OPA, 32);
    expect_f("byp_opa_rdy", 0, F_OPA_RDY, 1);
    expect_f("byp_opb_x0", 0, F_OPB, 0);
    expect_f("byp_opb_rdy", 0, F_OPB_RDY, 1);
    expect_f("byp_dest", 0, F_DEST, 38);
    expect_f("alloc_wins_opa", 1, F_OPA, 36);
    expect_f("alloc_wins_rdy", 1, F_OPA_RDY, 0);
    expect_f("alloc_wins_dest", 1, F_DEST, 39);
    run_step();

    clear_inputs();
    drive(0, add(9, 1, 0));
    expect_f("cdb_set_rdy", 0, F_OPA_RDY, 1);
    expect_f("cdb_set_dest", 0, F_DEST, 40);
    run_step();

    // nuke: no valid output, state reloaded from RRAT
    clear_inputs();
    nuke = 1'b1;
    drive(0, addi(1, 0, 1));
    drive(1, add(2, 3, 4));
    expect_f("nuke_valid", 0, F_VALID, 0);
    expect_f("nuke_valid", 1, F_VALID, 0);
    run_step();
    nuke = 1'b0;

    clear_inputs();
    drive(0, addi(1, 0, 1));
    drive(1, add(2, 1, 0));
    drive(2, add(3, 10, 0));
    drive(3, add(0, 1, 1));
    expect_f("post_nuke_dest", 0, F_DEST, 32);
    expect_f("post_nuke_opa", 1, F_OPA, 32);
    expect_f("post_nuke_rdy", 1, F_OPA_RDY, 0);
    expect_f("post_nuke_dest", 1, F_DEST, 33);
    expect_f("rrat_map_opa", 2, F_OPA, 10);
    expect_f("rrat_map_rdy", 2, F_OPA_RDY, 1);
    expect_f("rrat_map_dest", 2, F_DEST, 34);
    expect_f("x0_dest_valid", 3, F_VALID, 1);
    expect_f("x0_dest_tag", 3, F_DEST, 0);
    run_step();

    // drain the remaining tags 35..62
    for (int c = 0; c < 7; c++) begin
      clear_inputs();
      for (int s = 0; s < N; s++) drive(s, addi(s + 1, 0, c));
      expect_f("drain_dest", 0, F_DEST, 35 + 4 * c);
      expect_f("drain_dest", 3, F_DEST, 38 + 4 * c);
      run_step();
    end

    // one tag left: slot0 takes 63, slot1 starves, later slot also dropped
    clear_inputs();
    drive(0, addi(1, 0, 2));
    drive(1, addi(2, 0, 2));
    drive(2, add(0, 1, 1));
    expect_f("last_tag_valid", 0, F_VALID, 1);
    expect_f("last_tag_dest", 0, F_DEST, 63);
    expect_f("exhaust_valid", 1, F_VALID, 0);
    expect_f("exhaust_later", 2, F_VALID, 0);
    run_step();

    // release is only visible to allocation on the next cycle
    clear_inputs();
    drive(0, addi(5, 0, 3));
    free_vector_from_rrat = '0;
    free_vector_from_rrat[40] = 1'b1;
    expect_f("empty_valid", 0, F_VALID, 0);
    run_step();
    free_vector_from_rrat = '0;

    clear_inputs();
    drive(0, addi(6, 0, 3));
    drive(1, addi(7, 0, 3));
    expect_f("released_valid", 0, F_VALID, 1);
    expect_f("released_dest", 0, F_DEST, 40);
    expect_f("released_only", 1, F_VALID, 0);
    run_step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
